// File: rtl/sdram_write_packer.sv
// Packs a 32-bit word stream into 256-bit beats and releases them in 8-beat bursts,
// each burst paired with its byte-address instruction on the first beat.
module sdram_write_packer #(
   parameter int          BEAT_DEPTH = 16,
   parameter logic [31:0] PAD_WORD   = 32'h0
) (
   input  logic         clock,
   input  logic         reset_n,
   input  logic [31:0]  cfg_base_addr,
   input  logic [31:0]  cfg_word_count,
   input  logic         cfg_start,
   output logic         busy,
   output logic         done,
   output logic         cfg_error,
   input  logic         in_valid,
   input  logic [31:0]  in_data,
   output logic         in_ready,
   output logic         out_instruction_valid,
   output logic [31:0]  out_instruction_data,
   input  logic         out_instruction_ready,
   output logic         out_valid,
   output logic [255:0] out_data,
   input  logic         out_ready
);

   localparam int              PW         = (BEAT_DEPTH > 1) ? $clog2(BEAT_DEPTH) : 1;
   localparam int              CW         = $clog2(BEAT_DEPTH + 1);
   localparam logic [CW-1:0]   DEPTH_C    = CW'(BEAT_DEPTH);
   localparam logic [PW-1:0]   LAST_PTR   = PW'(BEAT_DEPTH - 1);
   localparam logic [34:0]     ADDR_LIMIT = 35'h1_0000_0000;

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_PAD, S_DRAIN} state_t;

   state_t          state_q, state_d;
   logic [31:0]     base_q, base_d;
   logic [31:0]     count_q, count_d;
   logic [31:0]     words_in_q, words_in_d;
   logic [2:0]      word_idx_q, word_idx_d;
   logic [2:0]      fill_beat_q, fill_beat_d;
   logic [255:0]    pack_q, pack_d;
   logic [CW-1:0]   fifo_count_q, fifo_count_d;
   logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]   bursts_ready_q, bursts_ready_d;
   logic [2:0]      beat_idx_q, beat_idx_d;
   logic [23:0]     burst_idx_q, burst_idx_d;
   logic            busy_q, busy_d;
   logic            done_q, done_d;
   logic            cfg_error_q, cfg_error_d;
   logic [255:0]    mem_q [BEAT_DEPTH];

   logic            in_ready_c, pad_go, word_acc, push, pop;
   logic            inst_vld, beat_vld;
   logic [31:0]     word_src, word_sw;
   logic [255:0]    pack_next;
   logic [26:0]     nbursts_c;
   logic [34:0]     span_c;
   logic            start_bad;

   // Only the 8th word of a beat needs FIFO space; the others just fill the pack register.
   assign in_ready_c = (state_q == S_RUN) && ((word_idx_q != 3'd7) || (fifo_count_q < DEPTH_C));
   assign pad_go     = (state_q == S_PAD) && ((word_idx_q != 3'd7) || (fifo_count_q < DEPTH_C));
   assign word_acc   = (in_valid && in_ready_c) || pad_go;
   assign push       = word_acc && (word_idx_q == 3'd7);
   assign word_src   = pad_go ? PAD_WORD : in_data;
   assign word_sw    = {word_src[7:0], word_src[15:8], word_src[23:16], word_src[31:24]};

   assign inst_vld = (bursts_ready_q != '0) && (beat_idx_q == 3'd0);
   assign beat_vld = (beat_idx_q == 3'd0) ? inst_vld : (fifo_count_q != '0);
   // The first beat only moves together with its instruction.
   assign pop      = beat_vld && out_ready && ((beat_idx_q != 3'd0) || out_instruction_ready);

   // Wide enough that huge word counts cannot wrap the end-address check.
   assign nbursts_c = 27'(({1'b0, cfg_word_count} + 33'd63) >> 6);
   assign span_c    = {3'b000, cfg_base_addr} + {nbursts_c, 8'h00};
   assign start_bad = (cfg_base_addr[7:0] != 8'h00) || (cfg_base_addr == 32'h0) ||
                      (span_c > ADDR_LIMIT);

   always_comb begin
      pack_next = pack_q;
      for (int k = 0; k < 8; k++) begin
         if (word_idx_q == 3'(k)) pack_next[255-32*k -: 32] = word_sw;
      end
   end

   always_comb begin
      state_d        = state_q;
      base_d         = base_q;
      count_d        = count_q;
      words_in_d     = words_in_q;
      word_idx_d     = word_idx_q;
      fill_beat_d    = fill_beat_q;
      pack_d         = pack_q;
      fifo_count_d   = fifo_count_q;
      wr_ptr_d       = wr_ptr_q;
      rd_ptr_d       = rd_ptr_q;
      bursts_ready_d = bursts_ready_q;
      beat_idx_d     = beat_idx_q;
      burst_idx_d    = burst_idx_q;
      busy_d         = busy_q;
      done_d         = 1'b0;
      cfg_error_d    = cfg_error_q;

      if (word_acc) begin
         word_idx_d = word_idx_q + 3'd1;
         pack_d     = push ? '0 : pack_next;
         if (push) fill_beat_d = fill_beat_q + 3'd1;
      end
      if (push) wr_ptr_d = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + 1'b1;
      if (pop) begin
         rd_ptr_d   = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + 1'b1;
         beat_idx_d = beat_idx_q + 3'd1;
         if (beat_idx_q == 3'd7) burst_idx_d = burst_idx_q + 24'd1;
      end
      if (push && !pop)      fifo_count_d = fifo_count_q + 1'b1;
      else if (!push && pop) fifo_count_d = fifo_count_q - 1'b1;

      // A burst becomes releasable when its 8th beat lands, and retires after its 8th beat leaves.
      if ((push && fill_beat_q == 3'd7) && !(pop && beat_idx_q == 3'd7))
         bursts_ready_d = bursts_ready_q + 1'b1;
      else if (!(push && fill_beat_q == 3'd7) && (pop && beat_idx_q == 3'd7))
         bursts_ready_d = bursts_ready_q - 1'b1;

      case (state_q)
         S_IDLE: begin
            if (cfg_start) begin
               if (start_bad) begin
                  cfg_error_d = 1'b1;
               end else begin
                  cfg_error_d = 1'b0;
                  base_d      = cfg_base_addr;
                  count_d     = cfg_word_count;
                  words_in_d  = '0;
                  word_idx_d  = '0;
                  fill_beat_d = '0;
                  pack_d      = '0;
                  beat_idx_d  = '0;
                  burst_idx_d = '0;
                  busy_d      = 1'b1;
                  state_d     = (cfg_word_count == 32'h0) ? S_DRAIN : S_RUN;
               end
            end
         end
         S_RUN: begin
            if (word_acc) begin
               words_in_d = words_in_q + 32'd1;
               if (words_in_q == count_q - 32'd1)
                  state_d = (count_q[5:0] == 6'd0) ? S_DRAIN : S_PAD;
            end
         end
         S_PAD: begin
            if (push && fill_beat_q == 3'd7) state_d = S_DRAIN;
         end
         S_DRAIN: begin
            if (fifo_count_q == '0 && bursts_ready_q == '0) begin
               done_d  = 1'b1;
               busy_d  = 1'b0;
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q        <= S_IDLE;
         base_q         <= '0;
         count_q        <= '0;
         words_in_q     <= '0;
         word_idx_q     <= '0;
         fill_beat_q    <= '0;
         pack_q         <= '0;
         fifo_count_q   <= '0;
         wr_ptr_q       <= '0;
         rd_ptr_q       <= '0;
         bursts_ready_q <= '0;
         beat_idx_q     <= '0;
         burst_idx_q    <= '0;
         busy_q         <= 1'b0;
         done_q         <= 1'b0;
         cfg_error_q    <= 1'b0;
      end else begin
         state_q        <= state_d;
         base_q         <= base_d;
         count_q        <= count_d;
         words_in_q     <= words_in_d;
         word_idx_q     <= word_idx_d;
         fill_beat_q    <= fill_beat_d;
         pack_q         <= pack_d;
         fifo_count_q   <= fifo_count_d;
         wr_ptr_q       <= wr_ptr_d;
         rd_ptr_q       <= rd_ptr_d;
         bursts_ready_q <= bursts_ready_d;
         beat_idx_q     <= beat_idx_d;
         burst_idx_q    <= burst_idx_d;
         busy_q         <= busy_d;
         done_q         <= done_d;
         cfg_error_q    <= cfg_error_d;
      end
   end

   // Beat storage carries no reset; out_data is gated so stale entries never show.
   always_ff @(posedge clock) begin
      if (push) mem_q[wr_ptr_q] <= pack_next;
   end

   assign in_ready              = in_ready_c;
   assign out_instruction_valid = inst_vld;
   assign out_instruction_data  = base_q + {burst_idx_q, 8'h00};
   assign out_valid             = beat_vld;
   assign out_data              = beat_vld ? mem_q[rd_ptr_q] : '0;
   assign busy                  = busy_q;
   assign done                  = done_q;
   assign cfg_error             = cfg_error_q;

endmodule
